change_dispenser: RTL and testbench

- Sits directly downstream of the vending controller and turns its change amount (chng, in 10-yen units) into physical coin ejections.
- Drives three coin hoppers (100, 50 and 10 yen) through a pulse/sense handshake.
- Pays out greedily, largest coin first, and falls back to smaller coins when a hopper is empty.
- Reports done or fault to the controller.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/coin_select.sv | 33 +++
 rtl/change_dispenser.sv | 132 +++++++++++++
 tb/tb_change_dispenser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants and state encoding for the vending controller and change dispenser.
package vend_pkg;

    localparam int unsigned AMT_W = 5;

    localparam logic [AMT_W-1:0] COIN10_UNITS  = AMT_W'(1);
    localparam logic [AMT_W-1:0] COIN50_UNITS  = AMT_W'(5);
    localparam logic [AMT_W-1:0] COIN100_UNITS = AMT_W'(10);

    localparam logic [AMT_W-1:0] CAN1_PRICE = AMT_W'(12);
    localparam logic [AMT_W-1:0] CAN2_PRICE = AMT_W'(13);
    localparam logic [AMT_W-1:0] CAN3_PRICE = AMT_W'(14);

    // One-hot denomination, bit order matches {eject100, eject50, eject10}
    localparam logic [2:0] DENOM_NONE = 3'b000;
    localparam logic [2:0] DENOM_100  = 3'b100;
    localparam logic [2:0] DENOM_50   = 3'b010;
    localparam logic [2:0] DENOM_10   = 3'b001;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StEject,
        StWaitAck,
        StDone,
        StFault
    } disp_state_e;

endpackage

// File: rtl/coin_select.sv
// Greedy denomination chooser: largest non-empty coin whose value fits in the amount owed.
module coin_select
    import vend_pkg::*;
(
    input  logic [AMT_W-1:0] remaining,
    input  logic             empty100,
    input  logic             empty50,
    input  logic             empty10,
    output logic [2:0]       denom,
    output logic [AMT_W-1:0] value,
    output logic             none_ok
);

    always_comb begin
        denom   = DENOM_NONE;
        value   = '0;
        none_ok = 1'b1;
        if (!empty100 && remaining >= COIN100_UNITS) begin
            denom   = DENOM_100;
            value   = COIN100_UNITS;
            none_ok = 1'b0;
        end else if (!empty50 && remaining >= COIN50_UNITS) begin
            denom   = DENOM_50;
            value   = COIN50_UNITS;
            none_ok = 1'b0;
        end else if (!empty10 && remaining >= COIN10_UNITS) begin
            denom   = DENOM_10;
            value   = COIN10_UNITS;
            none_ok = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount coin by coin through three hoppers with a pulse/sense handshake.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chng_valid,
    input  logic [AMT_W-1:0] chng,
    output logic             chng_ready,
    input  logic             empty100,
    input  logic             empty50,
    input  logic             empty10,
    input  logic             coin_sensed,
    output logic             eject100,
    output logic             eject50,
    output logic             eject10,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);

    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PulseLast   = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    disp_state_e      state;
    logic [PW-1:0]    pcnt;
    logic [TW-1:0]    tcnt;
    logic [AMT_W-1:0] value_q;
    logic             pending;

    logic [2:0]       sel_denom;
    logic [AMT_W-1:0] sel_value;
    logic             sel_none;
    logic             sensed;
    logic [AMT_W-1:0] diff;

    coin_select u_coin_select (
        .remaining (remaining),
        .empty100  (empty100),
        .empty50   (empty50),
        .empty10   (empty10),
        .denom     (sel_denom),
        .value     (sel_value),
        .none_ok   (sel_none)
    );

    assign sensed = coin_sensed | pending;
    assign diff   = remaining - value_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            chng_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            eject100   <= 1'b0;
            eject50    <= 1'b0;
            eject10    <= 1'b0;
            remaining  <= '0;
            pcnt       <= '0;
            tcnt       <= '0;
            value_q    <= '0;
            pending    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (chng_valid && chng_ready) begin
                        remaining  <= chng;
                        chng_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (chng == '0) ? StDone : StSelect;
                    end else begin
                        chng_ready <= 1'b1;
                    end
                end
                StSelect: begin
                    if (sel_none) begin
                        fault <= 1'b1;
                        state <= StFault;
                    end else begin
                        value_q                       <= sel_value;
                        {eject100, eject50, eject10}  <= sel_denom;
                        pcnt                          <= PulseLast;
                        pending                       <= 1'b0;
                        state                         <= StEject;
                    end
                end
                StEject: begin
                    // A fast sensor may fire before the pulse ends; keep one sense for WAIT_ACK
                    if (coin_sensed) pending <= 1'b1;
                    if (pcnt == '0) begin
                        {eject100, eject50, eject10} <= DENOM_NONE;
                        tcnt                         <= '0;
                        state                        <= StWaitAck;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end
                StWaitAck: begin
                    pending <= 1'b0;
                    if (sensed) begin
                        remaining <= diff;
                        state     <= (diff == '0) ? StDone : StSelect;
                    end else if (tcnt == TimeoutLast) begin
                        fault <= 1'b1;
                        state <= StFault;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StDone: begin
                    // chng_ready stays low for the done cycle and rises in the following one
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                StFault: begin
                end
                default: state <= StFault;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with an auto-responding coin sensor model.
module tb_change_dispenser;
    import vend_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             chng_valid = 1'b0;
    logic [AMT_W-1:0] chng = '0;
    logic             chng_ready;
    logic             empty100 = 1'b0;
    logic             empty50 = 1'b0;
    logic             empty10 = 1'b0;
    logic             coin_sensed = 1'b0;
    logic             eject100, eject50, eject10;
    logic             busy, done, fault;
    logic [AMT_W-1:0] remaining;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk         (clk),
        .rst         (rst),
        .chng_valid  (chng_valid),
        .chng        (chng),
        .chng_ready  (chng_ready),
        .empty100    (empty100),
        .empty50     (empty50),
        .empty10     (empty10),
        .coin_sensed (coin_sensed),
        .eject100    (eject100),
        .eject50     (eject50),
        .eject10     (eject10),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .remaining   (remaining)
    );

    logic [2:0] ej;
    assign ej = {eject100, eject50, eject10};

    int n_checks = 0;
    int n_bad = 0;

    // Monitor state: cumulative counts, written only by the monitor
    int run[3] = '{0, 0, 0};
    int cnt[3] = '{0, 0, 0};
    int denom_val[3] = '{10, 50, 100};
    int width_bad = 0;
    int done_cnt = 0;
    int sense_cnt = 0;
    int seq[$];
    int trace[$];
    logic [AMT_W-1:0] last_rem = '0;

    logic auto_sense = 1'b1;
    logic check_width = 1'b1;

    // Baselines, written only by the main process
    int b_cnt[3];
    int b_done, b_width, b_seq;

    always @(negedge clk) begin
        coin_sensed = 1'b0;
        if (sense_cnt > 0) begin
            sense_cnt--;
            if (sense_cnt == 0) coin_sensed = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (ej[i]) begin
                run[i]++;
            end else if (run[i] != 0) begin
                if (check_width && run[i] != 4) width_bad++;
                cnt[i]++;
                seq.push_back(denom_val[i]);
                run[i] = 0;
                if (auto_sense) sense_cnt = 2;
            end
        end
        if (done) done_cnt++;
        if (remaining != last_rem) begin
            trace.push_back(int'(remaining));
            last_rem = remaining;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) b_cnt[i] = cnt[i];
        b_done  = done_cnt;
        b_width = width_bad;
        b_seq   = seq.size();
    endtask

    task automatic send(input logic [AMT_W-1:0] amt);
        @(negedge clk);
        check("ready_before_req", 32'(chng_ready), 32'd1);
        chng       = amt;
        chng_valid = 1'b1;
        @(negedge clk);
        chng_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_level(input int idx, input logic lvl, input string tag);
        int k = 0;
        while (ej[idx] !== lvl && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(ej[idx]), 32'(lvl));
    endtask

    initial begin
        int k;
        int ts;
        int exp3[6] = '{17, 12, 7, 2, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(chng_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_ej", 32'(ej), 32'd0);
        check("rst_rem", 32'(remaining), 32'd0);
        rst = 1'b1;

        // 12 units: one 100-yen then two 10-yen
        snap();
        send(5'd12);
        wait_done(200, "t1_done");
        repeat (3) @(negedge clk);
        check("t1_n100", 32'(cnt[2] - b_cnt[2]), 32'd1);
        check("t1_n50", 32'(cnt[1] - b_cnt[1]), 32'd0);
        check("t1_n10", 32'(cnt[0] - b_cnt[0]), 32'd2);
        check("t1_first", 32'(seq[b_seq]), 32'd100);
        check("t1_last", 32'(seq[b_seq + 2]), 32'd10);
        check("t1_width", 32'(width_bad - b_width), 32'd0);
        check("t1_done_once", 32'(done_cnt - b_done), 32'd1);
        check("t1_rem", 32'(remaining), 32'd0);
        check("t1_ready", 32'(chng_ready), 32'd1);

        // Zero change: done two cycles after the request cycle, ready one cycle later
        snap();
        send(5'd0);
        check("t2_done_c1", 32'(done), 32'd0);
        check("t2_busy_c1", 32'(busy), 32'd1);
        @(negedge clk);
        check("t2_done_c2", 32'(done), 32'd1);
        check("t2_ready_c2", 32'(chng_ready), 32'd0);
        @(negedge clk);
        check("t2_done_c3", 32'(done), 32'd0);
        check("t2_ready_c3", 32'(chng_ready), 32'd1);
        check("t2_no_eject", 32'(seq.size() - b_seq), 32'd0);

        // 17 units with the 100-yen hopper empty
        empty100 = 1'b1;
        snap();
        ts = trace.size();
        send(5'd17);
        wait_done(300, "t3_done");
        repeat (2) @(negedge clk);
        empty100 = 1'b0;
        check("t3_n100", 32'(cnt[2] - b_cnt[2]), 32'd0);
        check("t3_n50", 32'(cnt[1] - b_cnt[1]), 32'd3);
        check("t3_n10", 32'(cnt[0] - b_cnt[0]), 32'd2);
        check("t3_trace_len", 32'(trace.size() - ts), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_rem%0d", i), 32'(trace[ts + i]), 32'(exp3[i]));

        // 3 units with the 10-yen hopper empty: fault straight from SELECT
        empty10 = 1'b1;
        snap();
        send(5'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ej_low", 32'(ej), 32'd0);
        end
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_rem", 32'(remaining), 32'd3);
        check("t4_no_done", 32'(done_cnt - b_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t4_fault_clr", 32'(fault), 32'd0);
        rst = 1'b1;
        empty10 = 1'b0;

        // 10 units, sensor never fires: fault after 64 WAIT_ACK cycles
        auto_sense = 1'b0;
        snap();
        send(5'd10);
        wait_level(2, 1'b1, "t5_ej_rise");
        wait_level(2, 1'b0, "t5_ej_fall");
        k = 0;
        while (!fault && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_timeout", 32'(k), 32'd64);
        check("t5_rem", 32'(remaining), 32'd10);
        chng       = 5'd5;
        chng_valid = 1'b1;
        repeat (4) @(negedge clk);
        chng_valid = 1'b0;
        check("t5_ignore_rem", 32'(remaining), 32'd10);
        check("t5_fault_held", 32'(fault), 32'd1);
        check("t5_ready_low", 32'(chng_ready), 32'd0);
        check("t5_n100", 32'(cnt[2] - b_cnt[2]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of an eject pulse
        check_width = 1'b0;
        send(5'd14);
        wait_level(2, 1'b1, "t6_ej_rise");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_ej100_drop", 32'(eject100), 32'd0);
        check("t6_ej_all", 32'(ej), 32'd0);
        check("t6_ready", 32'(chng_ready), 32'd1);
        check("t6_rem", 32'(remaining), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_width = 1'b1;
        auto_sense  = 1'b1;
        snap();
        send(5'd1);
        wait_done(100, "t6_done");
        repeat (2) @(negedge clk);
        check("t6_n10", 32'(cnt[0] - b_cnt[0]), 32'd1);
        check("t6_n100", 32'(cnt[2] - b_cnt[2]), 32'd0);
        check("t6_width", 32'(width_bad - b_width), 32'd0);
        check("t6_rem_end", 32'(remaining), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
